// File: rtl/tdc_stat_accum.sv
// tdc_stat_accum: collects a window of 2^WIN_LOG2 TDC Hamming-weight samples.
// It latches mean, min and max when the window completes and presents them on a
// registered 8-bit readout mux. val_in is synchronised here; hw_in is not.
// Optional feature macro: TDC_STAT_SPREAD_EN. When defined, a max-min spread
// register is added and rd_sel=3 returns it instead of the status byte.
module tdc_stat_accum #(
  parameter int HW_W     = 7,
  parameter int WIN_LOG2 = 4,
  parameter int N_SYNC   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            start,
  input  logic [HW_W-1:0] hw_in,
  input  logic            val_in,
  input  logic [1:0]      rd_sel,
  output logic [7:0]      rd_data,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam int SUM_W = HW_W + WIN_LOG2;
  localparam logic [WIN_LOG2-1:0] CNT_LAST = '1;

  function automatic logic [HW_W-1:0] min_f(input logic [HW_W-1:0] a, input logic [HW_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [HW_W-1:0] max_f(input logic [HW_W-1:0] a, input logic [HW_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  state_t                state_q, state_d;
  logic [N_SYNC-1:0]     sync_q, sync_d;
  logic                  edge_q, edge_d;
  logic [SUM_W-1:0]      sum_q, sum_d;
  logic [WIN_LOG2-1:0]   count_q, count_d;
  logic [HW_W-1:0]       work_min_q, work_min_d;
  logic [HW_W-1:0]       work_max_q, work_max_d;
  logic [HW_W-1:0]       res_mean_q, res_mean_d;
  logic [HW_W-1:0]       res_min_q, res_min_d;
  logic [HW_W-1:0]       res_max_q, res_max_d;
`ifdef TDC_STAT_SPREAD_EN
  logic [HW_W-1:0]       res_spread_q, res_spread_d;
`endif
  logic [7:0]            rd_data_q, rd_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  stb;
  logic [SUM_W-1:0]      new_sum;
  logic [HW_W-1:0]       new_min;
  logic [HW_W-1:0]       new_max;
  logic [5:0]            count6;

  // Next-state logic: strobe edge detect, FSM, accumulators, results and readout mux.
  always_comb begin
    sync_d       = {sync_q[N_SYNC-2:0], val_in};
    edge_d       = sync_q[N_SYNC-1];
    stb          = sync_q[N_SYNC-1] & ~edge_q;

    // Accumulator values including the current sample; also used for the final-sample result load.
    new_sum      = sum_q + SUM_W'(hw_in);
    new_min      = min_f(work_min_q, hw_in);
    new_max      = max_f(work_max_q, hw_in);
    count6       = 6'(count_q);

    state_d      = state_q;
    sum_d        = sum_q;
    count_d      = count_q;
    work_min_d   = work_min_q;
    work_max_d   = work_max_q;
    res_mean_d   = res_mean_q;
    res_min_d    = res_min_q;
    res_max_d    = res_max_q;
`ifdef TDC_STAT_SPREAD_EN
    res_spread_d = res_spread_q;
`endif

    if (!en) begin
      // Disable wins over start; the partial window is simply abandoned.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d    = ACCUM;
            sum_d      = '0;
            count_d    = '0;
            work_min_d = '1;
            work_max_d = '0;
          end
        end
        ACCUM: begin
          if (stb) begin
            sum_d      = new_sum;
            work_min_d = new_min;
            work_max_d = new_max;
            count_d    = count_q + 1'b1;
            if (count_q == CNT_LAST) begin
              state_d    = DONE;
              res_mean_d = HW_W'(new_sum >> WIN_LOG2);
              res_min_d  = new_min;
              res_max_d  = new_max;
`ifdef TDC_STAT_SPREAD_EN
              res_spread_d = new_max - new_min;
`endif
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == ACCUM);
    done_d = (state_d == DONE);

    case (rd_sel)
      2'd0:    rd_data_d = 8'(res_mean_q);
      2'd1:    rd_data_d = 8'(res_min_q);
      2'd2:    rd_data_d = 8'(res_max_q);
`ifdef TDC_STAT_SPREAD_EN
      default: rd_data_d = 8'(res_spread_q);
`else
      default: rd_data_d = {done_q, busy_q, count6};
`endif
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sync_q       <= '0;
      edge_q       <= 1'b0;
      sum_q        <= '0;
      count_q      <= '0;
      work_min_q   <= '1;
      work_max_q   <= '0;
      res_mean_q   <= '0;
      res_min_q    <= '0;
      res_max_q    <= '0;
`ifdef TDC_STAT_SPREAD_EN
      res_spread_q <= '0;
`endif
      rd_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      edge_q       <= edge_d;
      sum_q        <= sum_d;
      count_q      <= count_d;
      work_min_q   <= work_min_d;
      work_max_q   <= work_max_d;
      res_mean_q   <= res_mean_d;
      res_min_q    <= res_min_d;
      res_max_q    <= res_max_d;
`ifdef TDC_STAT_SPREAD_EN
      res_spread_q <= res_spread_d;
`endif
      rd_data_q    <= rd_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign rd_data = rd_data_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_tdc_stat_accum.sv
// Bench for tdc_stat_accum: scenario tasks with a queue-based window model.
module tb_tdc_stat_accum;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       start;
  logic [6:0] hw_in;
  logic       val_in;
  logic [1:0] rd_sel;
  logic [7:0] rd_data;
  logic       busy;
  logic       done;

  int nvec = 0;
  int nerr = 0;

  logic [6:0] win[$];
  int         exp_sum;
  logic [7:0] exp_mean, exp_min, exp_max;

  always #5 clk = ~clk;

  tdc_stat_accum #(.HW_W(7), .WIN_LOG2(4), .N_SYNC(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .hw_in(hw_in),
    .val_in(val_in), .rd_sel(rd_sel), .rd_data(rd_data), .busy(busy), .done(done)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // Reference: window statistics from the list of samples.
  function automatic void model_window();
    int mn, mx;
    exp_sum = 0;
    mn = 127;
    mx = 0;
    foreach (win[i]) begin
      exp_sum += int'(win[i]);
      if (int'(win[i]) < mn) mn = int'(win[i]);
      if (int'(win[i]) > mx) mx = int'(win[i]);
    end
    exp_mean = 8'(exp_sum / 16);
    exp_min  = 8'(mn);
    exp_max  = 8'(mx);
  endfunction

  // Expected rd_sel=3 word: status byte, or spread of the latched window.
  function automatic logic [7:0] exp3(input logic [7:0] status, input logic [7:0] mx, input logic [7:0] mn);
`ifdef TDC_STAT_SPREAD_EN
    return mx - mn;
`else
    return status;
`endif
  endfunction

  task automatic rd(input logic [1:0] s, output logic [7:0] v);
    @(posedge clk); #1 rd_sel = s;
    @(posedge clk);
    @(negedge clk);
    v = rd_data;
  endtask

  task automatic pulse(input logic [6:0] h, input int hold);
    @(posedge clk); #1 hw_in = h; val_in = 1'b1;
    repeat (hold) @(posedge clk);
    #1 val_in = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    en = 0; start = 0; hw_in = '0; val_in = 0; rd_sel = 2'd0; rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    nvec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      nerr++; $display("FAIL reset_flags got busy=%b done=%b exp 0 0", busy, done);
    end
    for (int s = 0; s < 4; s++) begin
      rd(2'(s), v);
      nvec++;
      if (v !== 8'h00) begin
        nerr++; $display("FAIL reset_rd sel=%0d got=%h exp=00", s, v);
      end
    end
    rd(2'd1, v);
    nvec++;
    if (v !== 8'h00) begin
      nerr++; $display("FAIL reset_min got=%h exp=00", v);
    end
  endtask

  task automatic test_constant();
    logic [7:0] v;
    logic [7:0] e[4];
    en = 1;
    do_start();
    @(negedge clk);
    nvec++;
    if (busy !== 1'b1) begin
      nerr++; $display("FAIL const_busy got=%b exp=1", busy);
    end
    win.delete();
    for (int i = 0; i < 15; i++) begin
      win.push_back(7'd32);
      pulse(7'd32, 2);
    end
    win.push_back(7'd32);
    @(posedge clk); #1 hw_in = 7'd32; val_in = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    nvec++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      nerr++; $display("FAIL const_stb_cycle got done=%b busy=%b exp 0 1", done, busy);
    end
    @(posedge clk);
    @(negedge clk);
    nvec++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      nerr++; $display("FAIL const_done_edge got done=%b busy=%b exp 1 0", done, busy);
    end
    val_in = 1'b0;
    repeat (3) @(posedge clk);
    model_window();
    e = '{exp_mean, exp_min, exp_max, exp3(8'h80, exp_max, exp_min)};
    for (int s = 0; s < 4; s++) begin
      rd(2'(s), v);
      nvec++;
      if (v !== e[s] || v !== ((s == 3) ? exp3(8'h80, 8'd32, 8'd32) : 8'd32)) begin
        nerr++; $display("FAIL const_rd sel=%0d got=%h exp=%h", s, v, e[s]);
      end
    end
  endtask

  task automatic test_ramp();
    logic [7:0] v;
    logic [7:0] e[4];
    do_start();
    win.delete();
    for (int i = 0; i < 16; i++) begin
      win.push_back(7'(i));
      pulse(7'(i), 1 + (i % 3));
    end
    model_window();
    nvec++;
    if (exp_sum != 120 || done !== 1'b1) begin
      nerr++; $display("FAIL ramp_sum_done got sum=%0d done=%b exp 120 1", exp_sum, done);
    end
    e = '{8'd7, 8'd0, 8'd15, exp3(8'h80, 8'd15, 8'd0)};
    for (int s = 0; s < 4; s++) begin
      rd(2'(s), v);
      nvec++;
      if (v !== e[s]) begin
        nerr++; $display("FAIL ramp_rd sel=%0d got=%h exp=%h", s, v, e[s]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [7:0] v;
    logic [7:0] e[4];
    do_start();
    win.delete();
    for (int i = 0; i < 16; i++) begin
      win.push_back(7'd127);
      pulse(7'd127, 2);
    end
    model_window();
    e = '{8'd127, 8'd127, 8'd127, exp3(8'h80, 8'd127, 8'd127)};
    for (int s = 0; s < 4; s++) begin
      rd(2'(s), v);
      nvec++;
      if (v !== e[s]) begin
        nerr++; $display("FAIL sat_rd sel=%0d got=%h exp=%h", s, v, e[s]);
      end
    end
    // One long val_in level in a new window counts once.
    do_start();
    @(posedge clk); #1 hw_in = 7'd5; val_in = 1'b1;
    repeat (50) @(posedge clk);
    #1 val_in = 1'b0;
    repeat (4) @(posedge clk);
    rd(2'd3, v);
    nvec++;
    if (v !== exp3(8'h41, 8'd127, 8'd127) || busy !== 1'b1) begin
      nerr++; $display("FAIL sat_long_val got=%h busy=%b exp=%h busy=1", v, busy, exp3(8'h41, 8'd127, 8'd127));
    end
  endtask

  task automatic test_abort();
    logic [7:0] v;
    logic [7:0] e[4];
    // en low with start high: disable wins.
    @(posedge clk); #1 en = 0; start = 1;
    @(posedge clk);
    @(negedge clk);
    nvec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      nerr++; $display("FAIL abort_en_wins got busy=%b done=%b exp 0 0", busy, done);
    end
    start = 0;
    en = 1;
    do_start();
    for (int i = 0; i < 5; i++) pulse(7'($urandom_range(0, 127)), 2);
    @(posedge clk); #1 en = 0;
    @(posedge clk);
    @(negedge clk);
    nvec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      nerr++; $display("FAIL abort_idle got busy=%b done=%b exp 0 0", busy, done);
    end
    e = '{8'd127, 8'd127, 8'd127, exp3(8'h05, 8'd127, 8'd127)};
    for (int s = 0; s < 3; s++) begin
      rd(2'(s), v);
      nvec++;
      if (v !== e[s]) begin
        nerr++; $display("FAIL abort_keep sel=%0d got=%h exp=%h", s, v, e[s]);
      end
    end
    en = 1;
    do_start();
    win.delete();
    for (int i = 0; i < 16; i++) begin
      win.push_back(7'd10);
      pulse(7'd10, 1);
    end
    model_window();
    e = '{exp_mean, exp_min, exp_max, exp3(8'h80, exp_max, exp_min)};
    for (int s = 0; s < 4; s++) begin
      rd(2'(s), v);
      nvec++;
      if (v !== e[s] || (s < 3 && v !== 8'd10)) begin
        nerr++; $display("FAIL abort_restart sel=%0d got=%h exp=%h", s, v, e[s]);
      end
    end
  endtask

  task automatic test_rearm();
    logic [7:0] v;
    logic [7:0] e[4];
    logic [6:0] h;
    pulse(7'd0, 2);
    rd(2'd3, v);
    nvec++;
    if (v !== exp3(8'h80, 8'd10, 8'd10)) begin
      nerr++; $display("FAIL rearm_done_stb got=%h exp=%h", v, exp3(8'h80, 8'd10, 8'd10));
    end
    rd(2'd1, v);
    nvec++;
    if (v !== 8'd10) begin
      nerr++; $display("FAIL rearm_done_min got=%h exp=0a", v);
    end
    do_start();
    @(negedge clk);
    nvec++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      nerr++; $display("FAIL rearm_flags got busy=%b done=%b exp 1 0", busy, done);
    end
    win.delete();
    for (int i = 0; i < 3; i++) begin
      h = 7'($urandom_range(0, 127));
      win.push_back(h);
      pulse(h, $urandom_range(1, 3));
    end
    rd(2'd0, v);
    nvec++;
    if (v !== 8'd10) begin
      nerr++; $display("FAIL rearm_old_mean got=%h exp=0a", v);
    end
    rd(2'd3, v);
    nvec++;
    if (v !== exp3(8'h43, 8'd10, 8'd10)) begin
      nerr++; $display("FAIL rearm_status got=%h exp=%h", v, exp3(8'h43, 8'd10, 8'd10));
    end
    for (int i = 0; i < 13; i++) begin
      h = 7'($urandom_range(0, 127));
      win.push_back(h);
      pulse(h, $urandom_range(1, 3));
    end
    model_window();
    e = '{exp_mean, exp_min, exp_max, exp3(8'h80, exp_max, exp_min)};
    for (int s = 0; s < 4; s++) begin
      rd(2'(s), v);
      nvec++;
      if (v !== e[s]) begin
        nerr++; $display("FAIL rearm_new sel=%0d got=%h exp=%h", s, v, e[s]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    logic [7:0] e[4];
    logic [6:0] h;
    for (int w = 0; w < 4; w++) begin
      do_start();
      win.delete();
      for (int i = 0; i < 16; i++) begin
        h = 7'($urandom_range(0, 127));
        win.push_back(h);
        pulse(h, $urandom_range(1, 4));
      end
      model_window();
      e = '{exp_mean, exp_min, exp_max, exp3(8'h80, exp_max, exp_min)};
      for (int s = 0; s < 4; s++) begin
        rd(2'(s), v);
        nvec++;
        if (v !== e[s]) begin
          nerr++; $display("FAIL rand_win w=%0d sel=%0d got=%h exp=%h", w, s, v, e[s]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_ramp();
    test_saturation();
    test_abort();
    test_rearm();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
